// File: rtl/dmem_access_ctrl_if.sv
// Data-RAM bus between the MEM-stage access sequencer and a single-port RAM.
//   master (sequencer): drives bus_req/bus_we/bus_addr/bus_be/bus_wdata,
//                       receives bus_ack/bus_rdata
//   slave  (RAM)      : the mirror image
// bus_req is held until bus_ack; bus_ack is a one-cycle completion pulse
// and bus_rdata is valid in that same cycle.
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Takes a load/store from EX/MEM, runs one req/ack transaction on the data
// bus while stalling the pipeline, and returns aligned, extended load data.
// Misaligned ops are flagged without touching the bus; a bus that does not
// ack within TIMEOUT_CYCLES request cycles is abandoned with bus_err.
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   op_*                  request from EX/MEM (valid, we, size, unsigned,
//                         byte address, right-justified store data)
//   stall                 hold IF..EX/MEM
//   load_data/load_valid  extended load result / one-cycle strobe
//   misalign              address/size exception (combinational)
//   bus_err               one-cycle timeout strobe
//   bus                   data-RAM bus (master side)
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  input  logic                      op_we,
  input  logic [1:0]                op_size,
  input  logic                      op_unsigned,
  input  logic [31:0]               op_addr,
  input  logic [31:0]               op_wdata,
  output logic                      stall,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      misalign,
  output logic                      bus_err,
  dmem_access_ctrl_if.master        bus
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state;
  logic [TO_WIDTH-1:0] cnt;
  logic [1:0]          size_r;
  logic [1:0]          lo_r;
  logic                uns_r;
  logic                misaligned;
  logic                accept;
  logic [3:0]          st_be;
  logic [31:0]         st_wd;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         ext;

  always_comb begin
    case (op_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = op_addr[0];
      2'b10:   misaligned = |op_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept   = (state == IDLE) & op_valid & ~misaligned;
  assign misalign = (state == IDLE) & op_valid & misaligned;
  assign stall    = accept | (state == REQ);

  // Store lane steering: replicate the datum across every lane so the RAM
  // only has to honour the byte enables.
  always_comb begin
    case (op_size)
      2'b00: begin
        st_be = 4'b0001 << op_addr[1:0];
        st_wd = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        st_be = op_addr[1] ? 4'b1100 : 4'b0011;
        st_wd = {2{op_wdata[15:0]}};
      end
      default: begin
        st_be = 4'b1111;
        st_wd = op_wdata;
      end
    endcase
  end

  // Load lane select and extension, evaluated on the ack cycle so the
  // already-extended value is what gets registered.
  always_comb begin
    case (lo_r)
      2'd0:    rd_byte = bus.bus_rdata[7:0];
      2'd1:    rd_byte = bus.bus_rdata[15:8];
      2'd2:    rd_byte = bus.bus_rdata[23:16];
      default: rd_byte = bus.bus_rdata[31:24];
    endcase
    rd_half = lo_r[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (size_r)
      2'b00:   ext = {{24{rd_byte[7] & ~uns_r}}, rd_byte};
      2'b01:   ext = {{16{rd_half[15] & ~uns_r}}, rd_half};
      default: ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      size_r        <= 2'b00;
      lo_r          <= 2'b00;
      uns_r         <= 1'b0;
      load_data     <= '0;
      load_valid    <= 1'b0;
      bus_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus.bus_addr  <= {op_addr[31:2], 2'b00};
          bus.bus_we    <= op_we;
          bus.bus_be    <= op_we ? st_be : 4'b1111;
          bus.bus_wdata <= st_wd;
          bus.bus_req   <= 1'b1;
          size_r        <= op_size;
          lo_r          <= op_addr[1:0];
          uns_r         <= op_unsigned;
          cnt           <= '0;
          state         <= REQ;
        end
        REQ: if (bus.bus_ack) begin
          bus.bus_req <= 1'b0;
          state       <= DONE;
          // load_data only moves on a completed load; it holds otherwise.
          if (!bus.bus_we) begin
            load_valid <= 1'b1;
            load_data  <= ext;
          end
        end else if (cnt == TO_LAST) begin
          bus.bus_req <= 1'b0;
          bus_err     <= 1'b1;
          state       <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // DONE lasts one cycle; op_valid here still names the finished op.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0, op_we = 1'b0, op_unsigned = 1'b0;
  logic [1:0]  op_size = 2'b00;
  logic [31:0] op_addr = '0, op_wdata = '0;
  logic        stall, load_valid, misalign, bus_err;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld = '0;

  // observations of the last run_op
  logic        o_stall0, o_mis, o_stall_req, o_stall_done, o_done, o_lv, o_err, o_unstable, o_we;
  int          o_reqs;
  logic [31:0] o_addr, o_wd, o_ld;
  logic [3:0]  o_be;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_we(op_we), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misalign(misalign),
    .bus_err(bus_err), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    int n;
    if (sz == 2'd3) return 1'b1;
    n = 1 << sz;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    logic [3:0] be;
    if (!we) return 4'hF;
    n = 1 << sz;
    off = int'(a[1:0]) & ~(n - 1);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] w;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] rd, input logic [1:0] sz,
                                       input logic uns, input logic [31:0] a);
    int bits;
    logic [31:0] s, mask;
    if (sz == 2'd2) return rd;
    bits = 8 << sz;
    s = rd >> (8 * int'(a[1:0]));
    mask = (32'h1 << bits) - 32'h1;
    s = s & mask;
    if (!uns && s[bits-1]) s = s | ~mask;
    return s;
  endfunction

  // ---------------- driver: one op, observations into o_* ----------------
  // ack_at = REQ-cycle index (0 = first) at which bus_ack is given; -1 = never
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at);
    @(posedge clk); #1;
    op_valid = 1'b1; op_we = we; op_size = sz; op_unsigned = uns;
    op_addr = addr; op_wdata = wd; bus.bus_ack = 1'b0;
    @(negedge clk);
    o_stall0 = stall; o_mis = misalign;
    o_reqs = 0; o_done = 0; o_stall_req = 1; o_unstable = 0;
    o_lv = 0; o_err = 0; o_stall_done = 1; o_ld = '0;
    for (int k = 0; k < TO + 4 && !o_done; k++) begin
      @(posedge clk); #1;
      bus.bus_ack = (k == ack_at);
      bus.bus_rdata = (k == ack_at) ? rd : $urandom;
      @(negedge clk);
      if (bus.bus_req) begin
        if (o_reqs == 0) begin
          o_addr = bus.bus_addr; o_be = bus.bus_be; o_wd = bus.bus_wdata; o_we = bus.bus_we;
        end else if ({bus.bus_addr, bus.bus_be, bus.bus_wdata, bus.bus_we} !==
                     {o_addr, o_be, o_wd, o_we}) o_unstable = 1;
        o_reqs++;
        o_stall_req &= stall;
      end else begin
        o_done = 1; o_lv = load_valid; o_ld = load_data; o_err = bus_err; o_stall_done = stall;
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0; bus.bus_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.bus_req, bus.bus_we, load_valid, bus_err, stall, misalign} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000000",
               {bus.bus_req, bus.bus_we, load_valid, bus_err, stall, misalign});
    end
    checks++;
    if ({bus.bus_addr, bus.bus_be, bus.bus_wdata, load_data} !== 100'b0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h exp zeros",
               bus.bus_addr, bus.bus_be, bus.bus_wdata, load_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ld = '0;
  endtask

  task automatic test_lw();
    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    checks++;
    if ({o_stall0, o_stall_req, o_reqs[3:0]} !== {2'b11, 4'd1}) begin
      errors++;
      $display("FAIL lw_stall got %b/%b/%0d exp 1/1/1", o_stall0, o_stall_req, o_reqs);
    end
    checks++;
    if ({o_addr, o_be, o_we} !== {32'h100, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL lw_bus got %h %b %b exp 00000100 1111 0", o_addr, o_be, o_we);
    end
    checks++;
    if ({o_lv, o_err, o_stall_done, o_ld} !== {3'b100, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL lw_done got lv%b err%b st%b %h exp lv1 err0 st0 deadbeef",
               o_lv, o_err, o_stall_done, o_ld);
    end
    exp_ld = 32'hDEADBEEF;
  endtask

  task automatic test_load_ext();
    run_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 1);
    checks++;
    if ({o_lv, o_ld} !== {1'b1, 32'hFFFFFF80}) begin
      errors++; $display("FAIL lb got %b %h exp 1 ffffff80", o_lv, o_ld);
    end
    run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 0);
    checks++;
    if ({o_lv, o_ld} !== {1'b1, 32'h00000080}) begin
      errors++; $display("FAIL lbu got %b %h exp 1 00000080", o_lv, o_ld);
    end
    run_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80112233, 2);
    checks++;
    if ({o_lv, o_ld, o_reqs[3:0]} !== {1'b1, 32'hFFFF8011, 4'd3}) begin
      errors++; $display("FAIL lh got %b %h %0d exp 1 ffff8011 3", o_lv, o_ld, o_reqs);
    end
    exp_ld = 32'hFFFF8011;
  endtask

  task automatic test_store();
    run_op(1'b1, 2'd0, 1'b0, 32'h201, 32'h000000A5, 32'h0, 0);
    checks++;
    if ({o_we, o_be, o_wd, o_addr} !== {1'b1, 4'b0010, 32'hA5A5A5A5, 32'h200}) begin
      errors++; $display("FAIL sb_bus got %b %b %h %h exp 1 0010 a5a5a5a5 00000200", o_we, o_be, o_wd, o_addr);
    end
    checks++;
    if ({o_lv, o_ld} !== {1'b0, exp_ld}) begin
      errors++; $display("FAIL sb_noload got %b %h exp 0 %h", o_lv, o_ld, exp_ld);
    end
    run_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234, 32'h0, 1);
    checks++;
    if ({o_we, o_be, o_wd, o_unstable} !== {1'b1, 4'b1100, 32'h12341234, 1'b0}) begin
      errors++; $display("FAIL sh_bus got %b %b %h unst%b exp 1 1100 12341234 unst0", o_we, o_be, o_wd, o_unstable);
    end
  endtask

  task automatic test_misalign();
    run_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 0);
    checks++;
    if ({o_mis, o_stall0, o_reqs[3:0], o_lv} !== {2'b10, 4'd0, 1'b0}) begin
      errors++; $display("FAIL mis_lw got mis%b st%b req%0d lv%b exp mis1 st0 req0 lv0", o_mis, o_stall0, o_reqs, o_lv);
    end
    run_op(1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    checks++;
    if ({o_mis, o_stall0, o_reqs[3:0]} !== {2'b10, 4'd0}) begin
      errors++; $display("FAIL mis_sz3 got mis%b st%b req%0d exp mis1 st0 req0", o_mis, o_stall0, o_reqs);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, -1);
    checks++;
    if ({o_reqs[3:0], o_stall_req, o_err, o_lv, o_stall_done} !== {4'd4, 4'b1100}) begin
      errors++; $display("FAIL timeout got req%0d st%b err%b lv%b std%b exp req4 st1 err1 lv0 std0",
                         o_reqs, o_stall_req, o_err, o_lv, o_stall_done);
    end
    // late ack while idle
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.bus_req, stall, load_valid, bus_err, load_data} !== {4'b0, exp_ld}) begin
      errors++; $display("FAIL late_ack got %b%b%b%b %h exp 0000 %h",
                         bus.bus_req, stall, load_valid, bus_err, load_data, exp_ld);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int reqs;
    reqs = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_we = 1'b0; op_size = 2'd2; op_unsigned = 1'b0; op_addr = 32'h400;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin rst_n = 1'b0; op_valid = 1'b0; end
      @(negedge clk);
      if (bus.bus_req) reqs++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    exp_ld = '0;
    checks++;
    if ({reqs[3:0], bus.bus_req, stall, load_valid, load_data} !== {4'd3, 3'b000, 32'h0}) begin
      errors++; $display("FAIL rst_mid got req%0d %b%b%b %h exp req3 000 00000000",
                         reqs, bus.bus_req, stall, load_valid, load_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd = $urandom;
    run_op(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, rd, 0);
    checks++;
    if ({o_reqs[3:0], o_lv, o_err, o_ld, o_addr} !== {4'd1, 2'b10, rd, 32'h404}) begin
      errors++; $display("FAIL rst_after got req%0d lv%b err%b %h %h exp req1 lv1 err0 %h 00000404",
                         o_reqs, o_lv, o_err, o_ld, o_addr, rd);
    end
    exp_ld = rd;
  endtask

  task automatic test_random();
    logic we, uns, mis, to;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    int ack_at, ereq;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom % 2); uns = 1'($urandom % 2);
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'h1 << sz) - 32'h1);
      ack_at = ($urandom % 6 == 0) ? -1 : int'($urandom % TO);
      run_op(we, sz, uns, a, wd, rd, ack_at);
      mis = m_mis(sz, a);
      to = (ack_at < 0);
      ereq = mis ? 0 : (to ? TO : ack_at + 1);
      if (!mis && !we && !to) exp_ld = m_ld(rd, sz, uns, a);
      checks++;
      if ({o_mis, o_stall0, o_stall_req, o_stall_done, o_done, o_unstable} !== {mis, !mis, 4'b1010}) begin
        errors++; $display("FAIL rand%0d_ctl got %b%b%b%b%b%b exp %b%b1010", i,
                           o_mis, o_stall0, o_stall_req, o_stall_done, o_done, o_unstable, mis, !mis);
      end
      checks++;
      if ({o_reqs, o_lv, o_err, o_ld} !== {ereq, !mis && !we && !to, !mis && to, exp_ld}) begin
        errors++; $display("FAIL rand%0d_res got req%0d lv%b err%b %h exp req%0d lv%b err%b %h", i,
                           o_reqs, o_lv, o_err, o_ld, ereq, !mis && !we && !to, !mis && to, exp_ld);
      end
      if (!mis) begin
        checks++;
        if ({o_addr, o_be, o_we, (we ? o_wd : 32'h0)} !==
            {a & ~32'h3, m_be(we, sz, a), we, (we ? m_wd(sz, wd) : 32'h0)}) begin
          errors++; $display("FAIL rand%0d_bus got %h %b %b %h exp %h %b %b %h", i,
                             o_addr, o_be, o_we, o_wd, a & ~32'h3, m_be(we, sz, a), we, m_wd(sz, wd));
        end
      end
    end
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
